// File: rtl/seq_multiplier.sv
// Multi-cycle NxN radix-2 shift-add multiplier with signed/unsigned modes,
// full 2N-bit product, ALU-style z/c/v/n flags and valid/ready handshakes.
module seq_multiplier #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         is_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result_lo,
  output logic [N-1:0] result_hi,
  output logic         z_flag,
  output logic         c_flag,
  output logic         v_flag,
  output logic         n_flag,
  output logic [1:0]   dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid are decoded from registered state only.

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_mcand;
  logic [N-1:0]     r_mplier;
  logic [2*N-1:0]   r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_signed;

  logic [N-1:0]     w_mag_a;
  logic [N-1:0]     w_mag_b;
  logic [N:0]       w_sum;
  logic [2*N-1:0]   w_acc_next;
  logic [2*N-1:0]   w_prod;
  logic [N-1:0]     w_prod_lo;
  logic [N-1:0]     w_prod_hi;

  // Magnitudes stay N-bit unsigned, so the most negative operand maps to 2^(N-1).
  assign w_mag_a = (is_signed && a[N-1]) ? (~a + N'(1)) : a;
  assign w_mag_b = (is_signed && b[N-1]) ? (~b + N'(1)) : b;

  assign w_sum      = {1'b0, r_acc[2*N-1:N]} + {1'b0, r_mcand};
  assign w_acc_next = r_mplier[0] ? {w_sum, r_acc[N-1:1]} : {1'b0, r_acc[2*N-1:1]};
  assign w_prod     = r_neg ? (~r_acc + (2*N)'(1)) : r_acc;
  assign w_prod_lo  = w_prod[N-1:0];
  assign w_prod_hi  = w_prod[2*N-1:N];

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_signed  <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      z_flag    <= 1'b0;
      c_flag    <= 1'b0;
      v_flag    <= 1'b0;
      n_flag    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_neg    <= is_signed & (a[N-1] ^ b[N-1]);
            r_signed <= is_signed;
            r_acc    <= '0;
            r_cnt    <= CW'(N);
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_acc    <= w_acc_next;
          r_mplier <= {1'b0, r_mplier[N-1:1]};
          r_cnt    <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= FIX;
        end
        FIX: begin
          result_lo <= w_prod_lo;
          result_hi <= w_prod_hi;
          z_flag    <= (w_prod_lo == '0);
          c_flag    <= ~r_signed & (w_prod_hi != '0);
          v_flag    <= r_signed & (w_prod_hi != {N{w_prod_lo[N-1]}});
          n_flag    <= w_prod_lo[N-1];
          r_state   <= DONE;
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised multi-cycle N×N multiplier for the execution unit. It supports signed and unsigned modes and returns the full 2N-bit product with ALU-style z/c/v/n flags. Operand and result transfers use valid/ready handshakes. It uses a radix-2 shift-add datapath, so the area cost of a combinational array multiplier is traded for N+1 cycles of latency.

## Interface
Parameters:
- N, 32, operand width in bits; legal range N ≥ 2.

Ports:
- clk  in  1  single clock domain; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-low; clears all state.
- in_valid  in  1  operand pair present on a/b/is_signed.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  N  multiplicand.
- b  in  N  multiplier.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  out  1  result and flags valid; high only in DONE.
- out_ready  in  1  consumer takes the result.
- result_lo  out  N  product bits [N-1:0].
- result_hi  out  N  product bits [2N-1:N].
- z_flag  out  1  result_lo == 0.
- c_flag  out  1  unsigned overflow: unsigned mode and result_hi != 0; 0 in signed mode.
- v_flag  out  1  signed overflow: signed mode and result_hi != {N{result_lo[N-1]}}; 0 in unsigned mode.
- n_flag  out  1  result_lo[N-1].

## Operation
FSM states: IDLE, CALC, FIX, DONE.

- **IDLE**
  - in_ready = 1.
  - On in_valid, capture the operand magnitudes: |a| and |b| when is_signed, else a and b raw. Also capture neg = is_signed & (a[N-1] ^ b[N-1]).
  - Clear the 2N-bit accumulator, load the iteration counter with N, go to CALC.
- **CALC**, one iteration per cycle:
  - If the multiplier LSB = 1, add the multiplicand into the upper half of the accumulator, with the carry kept.
  - Shift accumulator and multiplier right by 1; decrement the counter.
  - When the counter reaches 1 on this edge, go to FIX.
  - No early termination: every operation takes exactly N iterations.
- **FIX**
  - Product = neg ? two's-complement negation (2N bits) of the accumulator : accumulator.
  - Register result_hi, result_lo and all four flags, then go to DONE.
- **DONE**
  - out_valid = 1; outputs held stable.
  - On out_ready, go to IDLE.
- Arithmetic width rules:
  - Magnitudes are N-bit unsigned, so a = -2^(N-1) yields magnitude 2^(N-1) without overflow.
  - The full product always fits in 2N bits; no truncation before the flags are computed.
- in_valid, a, b and is_signed are ignored outside IDLE; no operand queueing.
- Outputs and flags keep the last result after leaving DONE, until the next FIX overwrites them.

## Timing
- Accept edge: the edge where in_valid & in_ready are both high (edge k).
- out_valid rises after edge k+N+1, i.e. N+1 cycles after acceptance (N CALC + 1 FIX).
- in_ready falls after edge k and returns only after the edge on which out_valid & out_ready are both high.
- Minimum issue interval: N+3 cycles (accept, N CALC, FIX, DONE with out_ready already high, back in IDLE).
- No combinational path from any input to any output. in_ready and out_valid are decoded from registered state only.
- Reset values, applied asynchronously as soon as rst is low:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - result_lo = result_hi = 0, z_flag = 0, c_flag = 0, v_flag = 0, n_flag = 0.
  - Accumulator, counter and neg cleared.
- Reset in CALC, FIX or DONE aborts the operation; no result is ever presented for it.
- The first rising edge after rst deasserts may accept new operands.

## Test plan
All cases use N=8 unless stated.
- Unsigned 200×3 → out_valid exactly 9 cycles after accept; result_hi=0x02, result_lo=0x58; c=1, v=0, z=0, n=0.
- Signed -3×5 → result_hi=0xFF, result_lo=0xF1; n=1, v=0, c=0. Signed -128×-1 → result_hi=0x00, result_lo=0x80; v=1, n=1, c=0.
- Unsigned 16×16 → result_hi=0x01, result_lo=0x00; z=1, c=1. Unsigned 0×255 → all zero, z=1, c=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, toggling in_valid with new operands → outputs stable, in_ready=0, new operands never captured. Then set out_ready=1 → IDLE next cycle.
- Assert rst mid-CALC (cycle 4) → all outputs go to reset values immediately with no clock edge; a fresh 7×9 after release → 0x003F with normal latency.
- N=32, signed -2^31 × -2^31 → result_hi=0x40000000, result_lo=0; v=1, z=1; out_valid 33 cycles after accept.
